cmd_rx_deserializer: RTL and testbench

CMD_RX_DESERIALIZER -- requirements
Module: cmd_rx_deserializer

---
 rtl/cmd_rx_deserializer_pkg.sv | 32 +++
 rtl/crc7_serial.sv | 28 ++
 rtl/cmd_rx_deserializer.sv | 139 +++++++++++++
 tb/tb_cmd_rx_deserializer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_rx_deserializer_pkg.sv
// Shared definitions for the SD CMD-line response receiver:
// FSM encoding, frame constants and the CRC7 step function.
package cmd_rx_deserializer_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        RECEIVE    = 3'd2,
        DONE       = 3'd3,
        TIMEOUT    = 3'd4
    } state_t;

    localparam logic [7:0] SHORT_LEN   = 8'd48;
    localparam logic [7:0] LONG_LEN    = 8'd136;
    localparam logic [6:0] NCR_TIMEOUT = 7'd64;
    localparam logic [6:0] CRC7_POLY   = 7'h09;

    // Frame-bit index ranges covered by the CRC
    localparam logic [7:0] SHORT_CRC_LAST = 8'd39;
    localparam logic [7:0] LONG_CRC_FIRST = 8'd8;
    localparam logic [7:0] LONG_CRC_LAST  = 8'd127;

    function automatic logic [6:0] crc7_step(
        input logic [6:0] crc,
        input logic       b
    );
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), initial value zero.
// Shared between the CMD receive and transmit paths.
module crc7_serial
    import cmd_rx_deserializer_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic       i_bit,
    output logic [6:0] o_crc
);

    logic [6:0] r_crc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_crc <= 7'h00;
        end else if (i_clear) begin
            r_crc <= 7'h00;
        end else if (i_enable) begin
            r_crc <= crc7_step(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/cmd_rx_deserializer.sv
// Receives a 48- or 136-bit response frame from the SD CMD line,
// checks transmission bit, end bit and CRC7, and flags Ncr timeouts.
module cmd_rx_deserializer
    import cmd_rx_deserializer_pkg::*;
(
    input  logic           sd_clock,
    input  logic           reset,
    input  logic           enable_rx,
    input  logic           long_response,
    input  logic           crc_check_en,
    input  logic           cmd_in,
    output logic [135:0]   pad_response,
    output logic           reception_complete,
    output logic           no_response,
    output logic           response_error
);

    state_t         r_state;
    logic           r_long;
    logic           r_crc_en;
    logic           r_tx_err;
    logic [6:0]     r_tmo_cnt;
    logic [7:0]     r_bit_cnt;
    logic [135:0]   r_shift;
    logic           r_done;
    logic           r_nores;
    logic           r_err;

    logic [6:0]     w_crc;
    logic           w_crc_clr;
    logic           w_crc_en;
    logic           w_in_crc;
    logic [7:0]     w_last;

    always_comb begin
        w_last    = (r_long ? LONG_LEN : SHORT_LEN) - 8'd1;
        w_in_crc  = r_long ? (r_bit_cnt >= LONG_CRC_FIRST &&
                              r_bit_cnt <= LONG_CRC_LAST)
                           : (r_bit_cnt <= SHORT_CRC_LAST);
        w_crc_clr = (r_state == IDLE);
        // The start bit enters the CRC as it is recognised in WAIT_START
        w_crc_en  = enable_rx && w_in_crc &&
                    ((r_state == WAIT_START && !cmd_in) ||
                     (r_state == RECEIVE));
    end

    crc7_serial u_crc7 (
        .i_clk    (sd_clock),
        .i_rst    (reset),
        .i_clear  (w_crc_clr),
        .i_enable (w_crc_en),
        .i_bit    (cmd_in),
        .o_crc    (w_crc)
    );

    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_long    <= 1'b0;
            r_crc_en  <= 1'b0;
            r_tx_err  <= 1'b0;
            r_tmo_cnt <= 7'd0;
            r_bit_cnt <= 8'd0;
            r_shift   <= '0;
            r_done    <= 1'b0;
            r_nores   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable_rx) begin
                        r_long    <= long_response;
                        r_crc_en  <= crc_check_en;
                        r_shift   <= '0;
                        r_tmo_cnt <= 7'd0;
                        r_bit_cnt <= 8'd0;
                        r_tx_err  <= 1'b0;
                        r_err     <= 1'b0;
                        r_state   <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (!enable_rx) begin
                        r_state <= IDLE;
                    end else if (!cmd_in) begin
                        r_shift   <= {r_shift[134:0], 1'b0};
                        r_bit_cnt <= 8'd1;
                        r_state   <= RECEIVE;
                    end else if (r_tmo_cnt == NCR_TIMEOUT - 7'd1) begin
                        r_tmo_cnt <= NCR_TIMEOUT;
                        r_nores   <= 1'b1;
                        r_state   <= TIMEOUT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 7'd1;
                    end
                end
                RECEIVE: begin
                    if (!enable_rx) begin
                        r_state <= IDLE;
                    end else begin
                        r_shift   <= {r_shift[134:0], cmd_in};
                        r_bit_cnt <= r_bit_cnt + 8'd1;
                        if (r_bit_cnt == 8'd1) begin
                            r_tx_err <= cmd_in;
                        end
                        // Received CRC sits in the low 7 shift bits here
                        if (r_bit_cnt == w_last) begin
                            r_done  <= 1'b1;
                            r_err   <= r_tx_err || !cmd_in ||
                                       (r_crc_en && (w_crc != r_shift[6:0]));
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!enable_rx) begin
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                TIMEOUT: begin
                    if (!enable_rx) begin
                        r_nores <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pad_response       = r_shift;
    assign reception_complete = r_done;
    assign no_response        = r_nores;
    assign response_error     = r_err;

endmodule

// File: tb/tb_cmd_rx_deserializer.sv
// Self-checking bench for cmd_rx_deserializer: fixed vector table,
// timeout/abort/reset sequences and random frames vs a division-based CRC model.
module tb_cmd_rx_deserializer;

    logic           sd_clock = 1'b0;
    logic           reset;
    logic           enable_rx;
    logic           long_response;
    logic           crc_check_en;
    logic           cmd_in;
    logic [135:0]   pad_response;
    logic           reception_complete;
    logic           no_response;
    logic           response_error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sd_clock = ~sd_clock;

    cmd_rx_deserializer dut (
        .sd_clock           (sd_clock),
        .reset              (reset),
        .enable_rx          (enable_rx),
        .long_response      (long_response),
        .crc_check_en       (crc_check_en),
        .cmd_in             (cmd_in),
        .pad_response       (pad_response),
        .reception_complete (reception_complete),
        .no_response        (no_response),
        .response_error     (response_error)
    );

    typedef struct {
        logic           lng;
        logic           cen;
        logic [135:0]   frame;
        int             idle;
        logic           exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [135:0] act,
                       input logic [135:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] crc_model(input logic [135:0] f,
                                              input int n, input int first,
                                              input int last);
        bit         a [0:159];
        int         len;
        logic [7:0] g;
        logic [6:0] r;
        g   = 8'h89;
        len = last - first + 1;
        for (int i = 0; i < 160; i++) a[i] = 1'b0;
        for (int i = 0; i < len; i++) a[i] = f[n - 1 - (first + i)];
        for (int i = 0; i < len; i++)
            if (a[i])
                for (int j = 0; j < 8; j++) a[i + j] ^= g[7 - j];
        for (int j = 0; j < 7; j++) r[6 - j] = a[len + j];
        return r;
    endfunction

    function automatic logic err_model(input logic [135:0] f,
                                       input logic lng, input logic cen);
        int         n;
        logic [6:0] c;
        n = lng ? 136 : 48;
        c = lng ? crc_model(f, n, 8, 127) : crc_model(f, n, 0, 39);
        return (f[n - 2] != 1'b0) || (f[0] != 1'b1) ||
               (cen && (c != f[7:1]));
    endfunction

    task automatic run_frame(input string name, input logic lng,
                             input logic cen, input logic [135:0] f,
                             input int idle, input logic exp_err);
        int n;
        n = lng ? 136 : 48;
        @(negedge sd_clock);
        enable_rx     = 1'b1;
        long_response = lng;
        crc_check_en  = cen;
        cmd_in        = 1'b1;
        for (int i = 0; i < idle; i++) begin
            @(negedge sd_clock);
            cmd_in        = 1'b1;
            long_response = 1'($urandom);
            crc_check_en  = 1'($urandom);
        end
        for (int i = 0; i < n; i++) begin
            @(negedge sd_clock);
            if (i == n - 1)
                chk({name, "/early_done"}, reception_complete, 1'b0);
            cmd_in        = f[n - 1 - i];
            long_response = 1'($urandom);
            crc_check_en  = 1'($urandom);
        end
        @(negedge sd_clock);
        chk({name, "/done"}, reception_complete, 1'b1);
        chk({name, "/pad"}, pad_response, f);
        chk({name, "/err"}, response_error, exp_err);
        chk({name, "/nores"}, no_response, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge sd_clock);
            cmd_in = 1'($urandom);
        end
        chk({name, "/hold_done"}, reception_complete, 1'b1);
        chk({name, "/hold_pad"}, pad_response, f);
        chk({name, "/hold_err"}, response_error, exp_err);
        enable_rx = 1'b0;
        @(negedge sd_clock);
        chk({name, "/clr_done"}, reception_complete, 1'b0);
        chk({name, "/kept_pad"}, pad_response, f);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t           tbl [7];
        logic [135:0]   f;
        logic [127:0]   rnd;
        logic           lng;
        logic           cen;
        int             r;

        tbl[0] = '{1'b0, 1'b1, 136'h110000090067, 5, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 136'h110000090069, 0, 1'b1};
        tbl[2] = '{1'b1, 1'b0,
                   136'h3FFFFF9999EEEE8888DDDD7777CCCC6601, 10, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 136'h510000090067, 3, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 136'h110000090066, 2, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 136'h110000090069, 1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 136'h110000090067, 63, 1'b0};

        reset         = 1'b1;
        enable_rx     = 1'b0;
        long_response = 1'b0;
        crc_check_en  = 1'b0;
        cmd_in        = 1'b1;
        repeat (3) @(negedge sd_clock);
        chk("rst/pad", pad_response, '0);
        chk("rst/done", reception_complete, 1'b0);
        chk("rst/nores", no_response, 1'b0);
        chk("rst/err", response_error, 1'b0);
        reset = 1'b0;

        for (int k = 0; k < 7; k++)
            run_frame($sformatf("tbl%0d", k), tbl[k].lng, tbl[k].cen,
                      tbl[k].frame, tbl[k].idle, tbl[k].exp_err);

        // Ncr timeout: 64 idle bits in WAIT_START
        @(negedge sd_clock);
        enable_rx = 1'b1;
        cmd_in    = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge sd_clock);
            if (i == 63) chk("tmo/early", no_response, 1'b0);
            cmd_in = 1'b1;
        end
        @(negedge sd_clock);
        chk("tmo/nores", no_response, 1'b1);
        chk("tmo/done", reception_complete, 1'b0);
        repeat (3) @(negedge sd_clock);
        chk("tmo/hold", no_response, 1'b1);
        enable_rx = 1'b0;
        @(negedge sd_clock);
        chk("tmo/clr_nores", no_response, 1'b0);
        chk("tmo/clr_done", reception_complete, 1'b0);

        // Abort by dropping enable_rx at bit 20
        f = 136'h110000090067;
        @(negedge sd_clock);
        enable_rx    = 1'b1;
        crc_check_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge sd_clock);
            cmd_in = f[47 - i];
        end
        @(negedge sd_clock);
        enable_rx = 1'b0;
        cmd_in    = f[27];
        repeat (4) begin
            @(negedge sd_clock);
            cmd_in = 1'($urandom);
        end
        chk("abort/done", reception_complete, 1'b0);
        chk("abort/nores", no_response, 1'b0);

        // Reset at bit 30 takes effect without a clock edge
        @(negedge sd_clock);
        enable_rx = 1'b1;
        cmd_in    = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge sd_clock);
            cmd_in = f[47 - i];
        end
        @(negedge sd_clock);
        reset = 1'b1;
        #1;
        chk("midrst/pad", pad_response, '0);
        chk("midrst/done", reception_complete, 1'b0);
        chk("midrst/nores", no_response, 1'b0);
        chk("midrst/err", response_error, 1'b0);
        @(negedge sd_clock);
        reset     = 1'b0;
        enable_rx = 1'b0;
        cmd_in    = 1'b0;
        repeat (70) @(negedge sd_clock);
        chk("midrst/idle_pad", pad_response, '0);
        chk("midrst/idle_done", reception_complete, 1'b0);
        chk("midrst/idle_nores", no_response, 1'b0);
        cmd_in = 1'b1;

        for (int k = 0; k < 24; k++) begin
            lng = ($urandom_range(0, 2) == 0);
            cen = 1'($urandom);
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            f   = '0;
            if (lng) begin
                f[135:128] = 8'h3F;
                f[127:8]   = rnd[119:0];
                f[7:1]     = crc_model(f, 136, 8, 127);
            end else begin
                f[45:8] = rnd[37:0];
                f[7:1]  = crc_model(f, 48, 0, 39);
            end
            f[0] = 1'b1;
            r = $urandom_range(0, 5);
            if (r == 1) f[$urandom_range(7, 1)] ^= 1'b1;
            if (r == 2) f[0] = 1'b0;
            if (r == 3) f[lng ? 134 : 46] = 1'b1;
            run_frame($sformatf("rnd%0d", k), lng, cen, f,
                      $urandom_range(0, 63), err_model(f, lng, cen));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
